// File: rtl/gf2m_pkg.sv
// Shared constants and types for the GF(2^233) multiplier and inversion controller.
// No logic; combinational helpers only.
// Field: f(x) = x^233 + x^74 + 1, processed D bits of B per cycle.
package gf2m_pkg;

  localparam int GF_M     = 233;
  localparam int GF_D     = 4;
  localparam int GF_NDIG  = (GF_M + GF_D - 1) / GF_D;
  localparam int GF_TAP   = 74;
  localparam int GF_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gf2m_digit_step.sv
// One digit iteration: nxt = (acc * x^D mod f) ^ (a * digit mod f).
// Purely combinational, completes within a single cycle.
// No handshake; the caller registers the result.
module gf2m_digit_step
  import gf2m_pkg::*;
#(
  parameter int M   = GF_M,
  parameter int D   = GF_D,
  parameter int TAP = GF_TAP
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  output logic [M-1:0] nxt
);

  // Multiply by x and fold x^M back as x^TAP + 1, so the result stays below degree M.
  function automatic logic [M-1:0] mulx(input logic [M-1:0] v);
    logic [M-1:0] r;
    r = {v[M-2:0], 1'b0};
    if (v[M-1]) begin
      r[0]   = r[0] ^ 1'b1;
      r[TAP] = r[TAP] ^ 1'b1;
    end
    return r;
  endfunction

  logic [M-1:0] sh;
  logic [M-1:0] ap;
  logic [M-1:0] prod;

  // Shift the accumulator by D and build a*digit from reduced powers a*x^j.
  always_comb begin
    sh   = acc;
    ap   = a;
    prod = '0;
    for (int j = 0; j < D; j++) begin
      sh = mulx(sh);
      if (digit[j]) prod = prod ^ ap;
      ap = mulx(ap);
    end
    nxt = sh ^ prod;
  end

endmodule

// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) multiplier, C = A*B mod f(x), B consumed MSB-digit first.
// Latency: OUT_VALID pulses NDIG cycles after the accepting edge.
// IN_VALID is ignored while BUSY; a new request in the DONE cycle runs back-to-back.
module gf2m_digit_mult
  import gf2m_pkg::*;
#(
  parameter int M = GF_M,
  parameter int D = GF_D
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic [M-1:0] C,
  output logic         OUT_VALID,
  output logic         BUSY
);

  localparam int NDIG = (M + D - 1) / D;
  localparam int BW   = NDIG * D;
  localparam logic [GF_CNT_W-1:0] LAST = GF_CNT_W'(NDIG - 1);

  state_t              state;
  logic [GF_CNT_W-1:0] cnt;
  logic [M-1:0]        a_reg;
  logic [BW-1:0]       b_reg;
  logic [M-1:0]        acc;
  logic [M-1:0]        step_nxt;
  logic [D-1:0]        digit;

  // Pick digit NDIG-1-cnt of the padded multiplier: first cycle takes the top digit.
  always_comb begin
    digit = '0;
    for (int j = 0; j < NDIG; j++) begin
      if (cnt == GF_CNT_W'(NDIG - 1 - j)) digit = b_reg[j*D +: D];
    end
  end

  gf2m_digit_step #(
    .M   (M),
    .D   (D),
    .TAP (GF_TAP)
  ) u_step (
    .acc   (acc),
    .a     (a_reg),
    .digit (digit),
    .nxt   (step_nxt)
  );

  // Control FSM with registered BUSY/OUT_VALID, operand latches and accumulator.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          acc <= step_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= ST_DONE;
            BUSY      <= 1'b0;
            OUT_VALID <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept; acc (and so C) holds until the next accept.
          OUT_VALID <= 1'b0;
          if (IN_VALID) begin
            a_reg <= A;
            b_reg <= BW'(B);
            acc   <= '0;
            cnt   <= '0;
            state <= ST_RUN;
            BUSY  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign C = acc;

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// Scoreboard bench for gf2m_digit_mult: directed timing/boundary cases, random pairs,
// and a field inversion chain through the multiplier.
// Expected products come from a bit-serial GF(2^233) reference model.
module tb_gf2m_digit_mult;

  localparam int W = 233;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic         OUT_VALID;
  logic         BUSY;

  gf2m_digit_mult dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .A         (A),
    .B         (B),
    .C         (C),
    .OUT_VALID (OUT_VALID),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] sb[$];

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: x^233 = x^74 + 1.
  function automatic logic [W-1:0] gf_mulx(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v << 1;
    if (v[W-1]) begin
      r[0]  = r[0] ^ 1'b1;
      r[74] = r[74] ^ 1'b1;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      r = gf_mulx(r);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] xpow(input int n);
    logic [W-1:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  // Result monitor: every OUT_VALID pulse consumes one expected entry.
  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1) begin
      if (sb.size() > 0) chk("c", C, sb.pop_front());
      else chk("spurious_ov", 1, 0);
    end
  end

  // Called at a negedge with the DUT idle or in DONE; returns at the negedge after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
    IN_VALID = 1'b1;
    A = a;
    B = b;
    sb.push_back(e);
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (OUT_VALID !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (OUT_VALID !== 1'b1) chk("timeout_ov", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] e, a, b, r;
    int c1, c2;

    RST = 1'b1;
    IN_VALID = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge CLK);
    chk("rst_c", C, 0);
    chk("rst_ov", OUT_VALID, 0);
    chk("rst_busy", BUSY, 0);
    RST = 1'b0;
    @(negedge CLK);

    // A=1: C=B, exact OUT_VALID/BUSY cycle placement, C held afterwards.
    b = 233'h12345;
    issue(233'd1, b, b);
    for (int k = 0; k <= 60; k++) begin
      chk($sformatf("busy_k%0d", k), BUSY, (k <= 58) ? 1 : 0);
      chk($sformatf("ov_k%0d", k), OUT_VALID, (k == 59) ? 1 : 0);
      if (k == 60) chk("c_hold", C, b);
      @(negedge CLK);
    end

    // Reduction: x^232 * x = x^233 = x^74 + 1.
    e = xpow(74) | xpow(0);
    issue(xpow(232), xpow(1), e);
    wait_ov();
    // Back-to-back: squaring x^200 -> x^400 = x^167 + x^82 + x^8, then x^232 squared in DONE.
    c1 = cyc;
    e = xpow(167) | xpow(82) | xpow(8);
    issue(xpow(200), xpow(200), e);
    wait_ov();
    c1 = cyc;
    // x^464 = x^231*(x^74+1) = x^305 + x^231, x^305 = x^72*(x^74+1) = x^146 + x^72.
    e = xpow(231) | xpow(146) | xpow(72);
    issue(xpow(232), xpow(232), e);
    wait_ov();
    c2 = cyc;
    chk("b2b_gap", W'(c2 - c1), 60);
    repeat (2) @(negedge CLK);

    // IN_VALID during RUN is ignored.
    a = rnd();
    b = rnd();
    issue(a, b, gf_mul(a, b));
    repeat (9) @(negedge CLK);
    IN_VALID = 1'b1;
    A = rnd();
    B = rnd();
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("ign_busy", BUSY, 1);
    wait_ov();
    repeat (2) @(negedge CLK);

    // Reset mid-RUN (with a simultaneous IN_VALID): aborted, no pulse, nothing accepted.
    a = rnd();
    b = rnd();
    issue(a, b, gf_mul(a, b));
    repeat (29) @(negedge CLK);
    RST = 1'b1;
    IN_VALID = 1'b1;
    A = rnd();
    B = rnd();
    void'(sb.pop_back());
    @(negedge CLK);
    RST = 1'b0;
    IN_VALID = 1'b0;
    chk("abort_c", C, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_ov", OUT_VALID, 0);
    for (int k = 0; k < 70; k++) begin
      if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) chk("abort_quiet", {OUT_VALID, BUSY}, 0);
      @(negedge CLK);
    end

    // Random stream, back-to-back, with boundary operands first.
    for (int i = 0; i < 400; i++) begin
      a = rnd();
      b = rnd();
      case (i)
        0: a = '0;
        1: b = '0;
        2: b = 233'd1;
        3: a = 233'd1;
        4: b = b | xpow(232);
        default: ;
      endcase
      issue(a, b, gf_mul(a, b));
      wait_ov();
    end

    // Inversion: r = a^(2^233-2) by square-and-multiply, then a*r must be 1.
    a = rnd() | 233'd1;
    r = a;
    for (int i = 231; i >= 1; i--) begin
      issue(r, r, gf_mul(r, r));
      r = gf_mul(r, r);
      wait_ov();
      issue(r, a, gf_mul(r, a));
      r = gf_mul(r, a);
      wait_ov();
    end
    issue(r, r, gf_mul(r, r));
    r = gf_mul(r, r);
    wait_ov();
    issue(a, r, 233'd1);
    wait_ov();
    repeat (2) @(negedge CLK);

    chk("sb_empty", W'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
